// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared types, FSM states and LFSR taps for the adder trojan checker
package adder_chk_pkg;

   typedef logic [8:0] vec_t;
   typedef logic [4:0] resp_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_COMPARE,
      S_DONE
   } state_t;

   // x^9 + x^5 + 1 on a left-shifting register: feedback = bit8 ^ bit4
   localparam vec_t LFSR_TAPS = 9'h110;

   function automatic resp_t golden_sum(vec_t v);
      return {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0000, v[8]};
   endfunction

endpackage

// File: rtl/adder_chk_vecgen.sv
// rtl/adder_chk_vecgen.sv - vector sequencer; ADDER_CHK_LFSR_EN selects LFSR order instead of a binary count
module adder_chk_vecgen
   import adder_chk_pkg::*;
#(
   parameter int NUM_VECTORS = 512
) (
   input  logic clk,
   input  logic rst_n,
   input  logic init,
   input  logic step,
   output vec_t vec,
   output logic last
);

   vec_t       vec_q, vec_d, vec_nxt;
   logic [8:0] idx_q, idx_d;

   always_comb begin
`ifdef ADDER_CHK_LFSR_EN
      // vector 0 is all-zero, then the LFSR runs from its seed 9'h001
      vec_nxt = (vec_q == '0) ? 9'h001 : {vec_q[7:0], ^(vec_q & LFSR_TAPS)};
`else
      vec_nxt = vec_q + 9'd1;
`endif
      vec_d = vec_q;
      idx_d = idx_q;
      if (init) begin
         vec_d = '0;
         idx_d = '0;
      end else if (step) begin
         vec_d = vec_nxt;
         idx_d = idx_q + 9'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q <= '0;
         idx_q <= '0;
      end else begin
         vec_q <= vec_d;
         idx_q <= idx_d;
      end
   end

   assign vec  = vec_q;
   assign last = (idx_q == 9'(NUM_VECTORS - 1));

endmodule

// File: rtl/adder_trojan_checker.sv
// rtl/adder_trojan_checker.sv - exhaustive 4-bit adder checker; vector order set by ADDER_CHK_LFSR_EN
module adder_trojan_checker
   import adder_chk_pkg::*;
#(
   parameter int NUM_VECTORS   = 512,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic [3:0] tv_a,
   output logic [3:0] tv_b,
   output logic       tv_cin,
   input  logic [3:0] dut_s,
   input  logic       dut_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [9:0] fail_count,
   output logic [8:0] first_fail_vec,
   output logic       first_fail_valid
);

   state_t     state_q, state_d;
   logic [3:0] settle_q, settle_d;
   logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d, ffv_q, ffv_d;
   logic [9:0] fail_q, fail_d;
   vec_t       ffvec_q, ffvec_d;
   vec_t       cur_vec;
   logic       vg_init, vg_step, vg_last, mismatch;

   adder_chk_vecgen #(.NUM_VECTORS(NUM_VECTORS)) u_vecgen (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (vg_init),
      .step  (vg_step),
      .vec   (cur_vec),
      .last  (vg_last)
   );

   assign mismatch = (golden_sum(cur_vec) != {dut_cout, dut_s});

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      ffv_d    = ffv_q;
      fail_d   = fail_q;
      ffvec_d  = ffvec_q;
      vg_init  = 1'b0;
      vg_step  = 1'b0;
      if (state_q != S_IDLE && abort) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               state_d = S_APPLY;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               ffv_d   = 1'b0;
               fail_d  = '0;
               vg_init = 1'b1;
            end
            S_APPLY: begin
               settle_d = 4'(SETTLE_CYCLES - 1);
               state_d  = (SETTLE_CYCLES == 0) ? S_COMPARE : S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_q == '0) state_d = S_COMPARE;
               else                settle_d = settle_q - 4'd1;
            end
            S_COMPARE: begin
               if (mismatch) begin
                  if (fail_q != 10'd1023) fail_d = fail_q + 10'd1;
                  if (!ffv_q) begin
                     ffv_d   = 1'b1;
                     ffvec_d = cur_vec;
                  end
               end
               if (vg_last) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = (fail_d == '0);
               end else begin
                  state_d = S_APPLY;
                  vg_step = 1'b1;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         ffv_q    <= 1'b0;
         fail_q   <= '0;
         ffvec_q  <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         ffv_q    <= ffv_d;
         fail_q   <= fail_d;
         ffvec_q  <= ffvec_d;
      end
   end

   assign tv_a             = cur_vec[3:0];
   assign tv_b             = cur_vec[7:4];
   assign tv_cin           = cur_vec[8];
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign fail_count       = fail_q;
   assign first_fail_vec   = ffvec_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_adder_trojan_checker.sv
// tb/tb_adder_trojan_checker.sv - self-checking bench for adder_trojan_checker (honours ADDER_CHK_LFSR_EN)
module tb_adder_trojan_checker;

   localparam int N = 512;
   localparam int S = 2;
   localparam int P = S + 2;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [3:0] tv_a, tv_b, dut_s;
   logic       tv_cin, dut_cout, busy, done, pass, ffv;
   logic [9:0] fail_count;
   logic [8:0] ffvec;
   logic [3:0] s_a, s_b, s_s;
   logic       s_cin, s_cout, s_busy, s_done, s_pass, s_ffv;
   logic [9:0] s_fc;
   logic [8:0] s_ffvec;

   int         checks = 0, errors = 0, cyc = 0, mode = 0;
   logic [8:0] trig_mask = '0, trig_pat = '0;
   logic [4:0] flip = '0;

   typedef struct {
      string      name;
      int         m;
      logic [8:0] mask;
      logic [8:0] pat;
      logic [4:0] fl;
      int         ecnt;
      logic [8:0] efirst;
      bit         epass;
   } run_rec_t;
   run_rec_t tbl[3];

   always #5 clk = ~clk;

   // adder under test: 0 = correct, 1 = bit-0 carry stuck at 1, 2 = trojan flips bits on a trigger pattern
   function automatic logic [4:0] faulty_add(logic [8:0] v, int m, logic [8:0] mk, logic [8:0] pt, logic [4:0] fl);
      int a = int'(v[3:0]), b = int'(v[7:4]), c = int'(v[8]);
      int r = a + b + c;
      if (m == 1) r = 2 * ((a >> 1) + (b >> 1) + 1) + ((a ^ b ^ c) & 1);
      else if (m == 2 && (v & mk) == pt) r = r ^ int'(fl);
      return 5'(r);
   endfunction

   function automatic logic [8:0] vec_of(int k);
      logic [8:0] l;
`ifdef ADDER_CHK_LFSR_EN
      if (k == 0) return 9'h000;
      l = 9'h001;
      for (int i = 1; i < k; i++) l = {l[7:0], l[8] ^ l[4]};
`else
      l = 9'(k);
`endif
      return l;
   endfunction

   always_comb {dut_cout, dut_s} = faulty_add({tv_cin, tv_b, tv_a}, mode, trig_mask, trig_pat, flip);
   always_comb {s_cout, s_s}     = faulty_add({s_cin, s_b, s_a}, 0, 9'h0, 9'h0, 5'h0);

   adder_trojan_checker u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .tv_a(tv_a), .tv_b(tv_b), .tv_cin(tv_cin), .dut_s(dut_s), .dut_cout(dut_cout),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .first_fail_vec(ffvec), .first_fail_valid(ffv)
   );

   adder_trojan_checker #(.NUM_VECTORS(1), .SETTLE_CYCLES(0)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .tv_a(s_a), .tv_b(s_b), .tv_cin(s_cin), .dut_s(s_s), .dut_cout(s_cout),
      .busy(s_busy), .done(s_done), .pass(s_pass), .fail_count(s_fc),
      .first_fail_vec(s_ffvec), .first_fail_valid(s_ffv)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
   endtask

   task automatic ref_run(input int nvec, input int m, input logic [8:0] mk, input logic [8:0] pt,
                          input logic [4:0] fl, output int cnt, output logic [8:0] first);
      int a, b, c;
      logic [8:0] v;
      cnt = 0;
      first = '0;
      for (int k = 0; k < nvec; k++) begin
         v = vec_of(k);
         a = int'(v[3:0]); b = int'(v[7:4]); c = int'(v[8]);
         if (int'(faulty_add(v, m, mk, pt, fl)) != a + b + c) begin
            if (cnt == 0) first = v;
            if (cnt < 1023) cnt++;
         end
      end
   endtask

   task automatic full_run(input string name, input int m, input logic [8:0] mk, input logic [8:0] pt,
                           input logic [4:0] fl, input int ecnt, input logic [8:0] efirst, input bit epass);
      mode = m; trig_mask = mk; trig_pat = pt; flip = fl;
      start_run();
      chk({name, "_busy_on"}, busy, 1);
      chk({name, "_fc_clear"}, fail_count, 0);
      chk({name, "_ffv_clear"}, ffv, 0);
      while (!done && cyc < N * P + 20) begin
         if ((cyc - 1) % P == 0) chk({name, "_tv"}, {tv_cin, tv_b, tv_a}, vec_of((cyc - 1) / P));
         tick();
      end
      chk({name, "_done_cycle"}, cyc, N * P + 1);
      chk({name, "_pass"}, pass, epass);
      chk({name, "_fail_count"}, fail_count, ecnt);
      chk({name, "_ffv"}, ffv, ecnt > 0);
      if (ecnt > 0) chk({name, "_ffvec"}, ffvec, efirst);
      tick();
      chk({name, "_done_pulse"}, done, 0);
      chk({name, "_busy_off"}, busy, 0);
      chk({name, "_pass_hold"}, pass, epass);
      chk({name, "_tv_hold"}, {tv_cin, tv_b, tv_a}, vec_of(N - 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ecnt, dones;
      logic [8:0] efirst, mk;

      tbl[0] = '{"correct", 0, 9'h000, 9'h000, 5'h00, 0, 9'h000, 1'b1};
      tbl[1] = '{"stuck_c0", 1, 9'h000, 9'h000, 5'h00, 256, 9'h000, 1'b0};
      tbl[2] = '{"trojan_a5", 2, 9'h1FF, 9'h0A5, 5'h10, 1, 9'h0A5, 1'b0};

      repeat (3) tick();
      chk("rst_tv", {tv_cin, tv_b, tv_a}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_fc", fail_count, 0);
      chk("rst_ffv", ffv, 0);
      chk("rst_ffvec", ffvec, 0);
      rst_n = 1'b1;
      tick();

      // single-vector, zero-settle instance: done three cycles after start
      start_run();
      chk("small_done_c1", s_done, 0);
      chk("small_busy_c1", s_busy, 1);
      tick();
      chk("small_done_c2", s_done, 0);
      tick();
      chk("small_done_c3", s_done, 1);
      chk("small_pass", s_pass, 1);
      chk("small_fc", s_fc, 0);
      chk("small_ffv", s_ffv, 0);
      chk("small_tv", {s_cin, s_b, s_a}, 0);
      tick();
      chk("small_done_c4", s_done, 0);
      chk("small_busy_c4", s_busy, 0);
      chk("small_tv_hold", {s_cin, s_b, s_a}, 0);
      while (!done && cyc < N * P + 20) tick();
      chk("first_run_done_cycle", cyc, N * P + 1);
      tick();

      for (int i = 0; i < 3; i++)
         full_run(tbl[i].name, tbl[i].m, tbl[i].mask, tbl[i].pat, tbl[i].fl,
                  tbl[i].ecnt, tbl[i].efirst, tbl[i].epass);

      for (int i = 0; i < 2; i++) begin
         mk = 9'($urandom) & 9'($urandom) | 9'h003;
         trig_pat = 9'($urandom) & mk;
         flip = 5'($urandom_range(1, 31));
         ref_run(N, 2, mk, trig_pat, flip, ecnt, efirst);
         full_run("random", 2, mk, trig_pat, flip, ecnt, efirst, ecnt == 0);
      end

      // abort on cycle 100 (compare of vector 24), with a stray start mid-run
      mode = 1;
      start_run();
      while (cyc < 100) begin
         if (cyc == 50) start = 1'b1;
         tick();
         start = 1'b0;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pass", pass, 0);
      ref_run(24, 1, 9'h0, 9'h0, 5'h0, ecnt, efirst);
      chk("abort_fc", fail_count, ecnt);
      chk("abort_ffv", ffv, 1);
      chk("abort_ffvec", ffvec, efirst);
      dones = 0;
      repeat (8) begin
         tick();
         if (done) dones++;
      end
      chk("abort_no_done", dones, 0);
      full_run("restart", 0, 9'h0, 9'h0, 5'h0, 0, 9'h0, 1'b1);

      // reset while vector 37 is applied
      mode = 1;
      start_run();
      while (cyc < 1 + 37 * P) tick();
      chk("v37_tv", {tv_cin, tv_b, tv_a}, vec_of(37));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tv", {tv_cin, tv_b, tv_a}, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_pass", pass, 0);
      chk("mid_rst_fc", fail_count, 0);
      chk("mid_rst_ffv", ffv, 0);
      chk("mid_rst_ffvec", ffvec, 0);
      tick();
      tick();
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         tick();
         if (done || busy) dones++;
      end
      chk("post_rst_idle", dones, 0);
      full_run("post_rst", 1, 9'h0, 9'h0, 5'h0, 256, 9'h000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_trojan_checker.md
ADDER_TROJAN_CHECKER -- requirements
Module: adder_trojan_checker

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 512, number of vectors applied per run (1..512).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, cycles a vector is held before the response is sampled (0..15).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-006 SHALL have port abort  in  1  terminate the current run, returning to IDLE.
REQ-007 SHALL have ports tv_a, tv_b  out  4 each  operand vectors driven to the 4-bit adder under test.
REQ-008 SHALL have port tv_cin  out  1  carry-in driven to the adder under test.
REQ-009 SHALL have port dut_s  in  4  sum returned by the adder under test.
REQ-010 SHALL have port dut_cout  in  1  carry-out returned by the adder under test.
REQ-011 SHALL have port busy  out  1  high from the cycle after start until the run ends.
REQ-012 SHALL have port done  out  1  one-cycle pulse at normal run completion.
REQ-013 SHALL have port pass  out  1  high after a completed run with zero mismatches.
REQ-014 SHALL have port fail_count  out  10  mismatching vectors in the current or last run.
REQ-015 SHALL have port first_fail_vec  out  9  first mismatching vector, packed as {cin,b,a}.
REQ-016 SHALL have port first_fail_valid  out  1  first_fail_vec holds a captured value.

Function
REQ-017 SHALL map vector v[8:0] as tv_a=v[3:0], tv_b=v[7:4], tv_cin=v[8], with tv_* registered outputs.
REQ-018 SHALL implement FSM IDLE -> APPLY -> SETTLE -> COMPARE -> (APPLY | DONE) -> IDLE.
REQ-019 SHALL load vector k onto tv_* on entry to APPLY, hold it for 1+SETTLE_CYCLES cycles (SETTLE skipped when 0), then sample dut_* in COMPARE.
REQ-020 SHALL compute golden {cout,s} = a+b+cin at 5-bit width and flag a mismatch if it differs from {dut_cout,dut_s}.
REQ-021 SHALL, on a mismatch, increment fail_count saturating at 1023 and, if first_fail_valid is low, capture the vector and set first_fail_valid.
REQ-022 SHALL, after vector NUM_VECTORS-1 is compared, enter DONE for one cycle asserting done, setting pass = (fail_count==0), and deasserting busy in the following cycle.
REQ-023 SHALL clear fail_count, first_fail_valid, and pass on an accepted start; start while busy SHALL be ignored.
REQ-024 SHALL, when abort is high in any non-IDLE state, return to IDLE next cycle without pulsing done, keep pass low, and retain fail_count/first_fail_*; abort has priority over start and COMPARE in the same cycle.
REQ-025 SHALL take NUM_VECTORS*(SETTLE_CYCLES+2)+1 cycles from the start cycle to the done pulse.
REQ-026 SHALL hold tv_* at the last applied vector while idle.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE; tv_*=0; busy, done, pass, first_fail_valid=0; fail_count=0; first_fail_vec=0.
REQ-028 SHALL abandon a run in progress on reset assertion, with no done pulse.

Configuration
REQ-029 SHALL support macro ADDER_CHK_LFSR_EN: when defined, vector 0 is 9'h000, followed by the 9-bit LFSR x^9+x^5+1 sequence seeded 9'h001; when undefined, vectors are binary count 0..NUM_VECTORS-1.

Structure
REQ-030 SHALL place the vector type (9 bit), response type (5 bit), FSM state enum, and LFSR tap constant in package adder_chk_pkg.
REQ-031 SHALL implement vector sequencing (counter/LFSR, index, last-vector flag) in sub-module adder_chk_vecgen.

Verification
REQ-032 Correct adder model, defaults, start -> done at cycle 2049, pass=1, fail_count=0, first_fail_valid=0.
REQ-033 Adder with bit-0 carry stuck at 1, defaults, binary mode -> fail_count=256, first_fail_vec=9'h000, pass=0.
REQ-034 SETTLE_CYCLES=0, NUM_VECTORS=1, correct adder -> done 3 cycles after start, tv_*=0 held.
REQ-035 Abort on cycle 100, then restart -> no done from first run; second run counts from zero and completes normally.
REQ-036 rst_n low mid-run on vector 37 -> all outputs at reset values immediately; start after release runs fully.
REQ-037 ADDER_CHK_LFSR_EN defined, NUM_VECTORS=3 -> applied vectors 9'h000, 9'h001, 9'h002.
